audio_bus_master_streamer: RTL and testbench
============================================

Name: audio_bus_master_streamer

Overview:
- Initiator-side engine that drives the audio core's external bus-master interface (16-bit address, 32-bit data, read/write with acknowledge) from fabric logic.
- After reset it clears the core's FIFOs, then loops: polls FIFOSPACE, reads one left/right ADC sample pair, applies mute and attenuation, and writes the pair back to the DAC FIFOs.
- Result is a hardware line-in to line-out path, with each captured sample pair also exposed to fabric.

Parameters:
- AUDIO_BASE, 16'h0000, byte address of the audio core register block (CONTROL +0, FIFOSPACE +4, LEFTDATA +8, RIGHTDATA +12).
- SAMPLE_BITS, 24, valid sample width in LEFTDATA/RIGHTDATA; bit SAMPLE_BITS-1 is the sign bit.
- ACK_TIMEOUT_CYCLES, 1024, acknowledge wait limit; used only with the optional feature.

Ports:
- clk_clk  in  1  system clock; all logic on rising edge.
- reset_reset_n  in  1  synchronous, active-low reset.
- enable  in  1  run streaming loop.
- mute  in  1  write zero samples to the DAC instead of attenuated data.
- volume_shift  in  4  arithmetic right-shift applied to samples (0 = unity).
- address  out  16  bus address.
- byte_enable  out  4  always 4'b1111 during a transaction, 0 otherwise.
- read  out  1  read request.
- write  out  1  write request.
- write_data  out  32  write payload.
- acknowledge  in  1  transaction complete.
- read_data  in  32  read payload, valid in the acknowledge cycle.
- sample_valid  out  1  one-cycle pulse when a new left/right pair is captured.
- left_sample  out  32  last captured left sample, sign-extended.
- right_sample  out  32  last captured right sample, sign-extended.
- frame_count  out  32  completed DAC pair writes; wraps 2^32-1 -> 0.
- busy  out  1  high in any state except IDLE.
- bus_error  out  1  sticky ack-timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset (reset_reset_n low at an edge):
  - All outputs go to 0, the FSM goes to INIT_CLR, and any acknowledge still in flight is ignored.
  - Reset asserted mid-transaction drops read/write on that same edge.
- Bus handshake:
  - The FSM asserts read or write (never both), together with address, byte_enable and write_data.
  - All of these are held stable until acknowledge is sampled high.
  - On the ack edge the request is deasserted and read_data is captured.
  - One idle cycle is required between transactions, so minimum transaction length is 2 cycles including the idle.
- FSM states and transitions:
  - INIT_CLR: write CONTROL = 32'h0000_000C (clear read and write FIFOs) -> INIT_REL.
  - INIT_REL: write CONTROL = 32'h0 -> IDLE.
  - IDLE: busy = 0. If enable = 1 -> POLL.
  - POLL: read FIFOSPACE -> CHECK.
  - CHECK: RARC = [7:0], RALC = [15:8], WSRC = [23:16], WSLC = [31:24].
    - If enable = 0 -> IDLE.
    - Else if all four fields are nonzero -> RD_L.
    - Else -> POLL.
  - RD_L: read LEFTDATA -> RD_R.
  - RD_R: read RIGHTDATA. On ack, pulse sample_valid and update left_sample/right_sample -> WR_L.
  - WR_L: write processed left sample to LEFTDATA -> WR_R.
  - WR_R: write processed right sample to RIGHTDATA. On ack, frame_count += 1 -> CHECK via POLL (i.e. -> POLL).
- enable is sampled only in IDLE and CHECK; a started frame always completes through WR_R.
- Sample arithmetic:
  - s = sign-extend(read_data[SAMPLE_BITS-1:0]) to 32 bits.
  - Processed value = mute ? 0 : (s >>> volume_shift).
  - mute and volume_shift are sampled when the write request is first asserted and held for that transaction.
- Boundary values:
  - volume_shift = 15 with s = -1 gives -1 (arithmetic shift).
  - Positive values shift toward 0.

Optional Feature:
- Macro: AUDIO_ACK_TIMEOUT_EN.
- Defined:
  - A counter clears when a request is asserted and increments each cycle without acknowledge.
  - On reaching ACK_TIMEOUT_CYCLES, the request is dropped, bus_error is set (sticky until reset) and the FSM goes to INIT_CLR.
  - An ack arriving in the same cycle as the timeout wins; no error is flagged.
- Not defined: the block waits indefinitely for acknowledge, no counter is built, and bus_error is constant 0.

Test Plan:
- Reset then release, core acks after 1 cycle -> writes 32'h0000000C then 32'h0 to address AUDIO_BASE+0, then enters IDLE with busy = 0.
- enable = 1, FIFOSPACE = 32'h01010101, LEFTDATA = 24'h800000, RIGHTDATA = 24'h000100, volume_shift = 4 -> left_sample = 32'hFF800000, right_sample = 32'h00000100, sample_valid pulses once, writes 32'hFFF80000 and 32'h00000010, frame_count = 1.
- FIFOSPACE = 32'h00010101 (WSLC = 0) -> only repeated reads of AUDIO_BASE+4, no data reads or writes, frame_count unchanged.
- mute = 1 with any samples -> both DAC writes carry 32'h0; sample outputs still update.
- Hold acknowledge low for 5 cycles in RD_L -> read and address stay stable for all 5 cycles; a single capture occurs; request drops the cycle after the ack.
- With AUDIO_ACK_TIMEOUT_EN and ACK_TIMEOUT_CYCLES = 8, never ack -> request drops after 8 cycles, bus_error = 1, CONTROL clear write reissued; reset_reset_n low clears bus_error.

Source files
------------

// File: rtl/audio_bus_master_streamer.sv
// Bus-master engine: clears the audio core FIFOs, then loops ADC sample pairs back to the DAC with mute/attenuation.
// Optional acknowledge timeout with sticky bus_error is enabled by defining AUDIO_ACK_TIMEOUT_EN.
module audio_bus_master_streamer #(
    parameter logic [15:0] AUDIO_BASE         = 16'h0000,
    parameter int          SAMPLE_BITS        = 24,
    parameter int          ACK_TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    input  logic        mute,
    input  logic [3:0]  volume_shift,
    output logic [15:0] address,
    output logic [3:0]  byte_enable,
    output logic        read,
    output logic        write,
    output logic [31:0] write_data,
    input  logic        acknowledge,
    input  logic [31:0] read_data,
    output logic        sample_valid,
    output logic [31:0] left_sample,
    output logic [31:0] right_sample,
    output logic [31:0] frame_count,
    output logic        busy,
    output logic        bus_error
);

    localparam logic [15:0] ADDR_CONTROL   = AUDIO_BASE + 16'd0;
    localparam logic [15:0] ADDR_FIFOSPACE = AUDIO_BASE + 16'd4;
    localparam logic [15:0] ADDR_LEFT      = AUDIO_BASE + 16'd8;
    localparam logic [15:0] ADDR_RIGHT     = AUDIO_BASE + 16'd12;

    typedef enum logic [3:0] {
        INIT_CLR = 4'd0,
        INIT_REL = 4'd1,
        IDLE     = 4'd2,
        POLL     = 4'd3,
        CHECK    = 4'd4,
        RD_L     = 4'd5,
        RD_R     = 4'd6,
        WR_L     = 4'd7,
        WR_R     = 4'd8
    } state_t;

    function automatic logic [31:0] sign_extend(input logic [31:0] raw);
        logic [31:0] ext;
        for (int i = 0; i < 32; i++) begin
            ext[i] = (i < SAMPLE_BITS) ? raw[i] : raw[SAMPLE_BITS-1];
        end
        return ext;
    endfunction

    function automatic logic [31:0] process_sample(input logic [31:0] s, input logic m,
                                                   input logic [3:0] sh);
        return m ? 32'h0000_0000 : 32'($signed(s) >>> sh);
    endfunction

    state_t      state_r;
    logic [31:0] fifospace_r;
    logic [31:0] left_raw_r;

    logic        is_bus_s;
    logic        req_write_s;
    logic [15:0] req_addr_s;
    logic [31:0] req_data_s;
    logic        req_active_s;
    logic        space_ok_s;

    assign req_active_s = read | write;
    assign space_ok_s   = (|fifospace_r[7:0]) & (|fifospace_r[15:8]) &
                          (|fifospace_r[23:16]) & (|fifospace_r[31:24]);

    // Decode the transaction each bus state issues; mute/shift are captured when it is launched.
    always_comb begin
        is_bus_s    = 1'b1;
        req_write_s = 1'b0;
        req_addr_s  = ADDR_CONTROL;
        req_data_s  = 32'h0000_0000;
        case (state_r)
            INIT_CLR: begin
                req_write_s = 1'b1;
                req_data_s  = 32'h0000_000C;
            end
            INIT_REL: begin
                req_write_s = 1'b1;
            end
            POLL:     req_addr_s = ADDR_FIFOSPACE;
            RD_L:     req_addr_s = ADDR_LEFT;
            RD_R:     req_addr_s = ADDR_RIGHT;
            WR_L: begin
                req_write_s = 1'b1;
                req_addr_s  = ADDR_LEFT;
                req_data_s  = process_sample(left_sample, mute, volume_shift);
            end
            WR_R: begin
                req_write_s = 1'b1;
                req_addr_s  = ADDR_RIGHT;
                req_data_s  = process_sample(right_sample, mute, volume_shift);
            end
            default:  is_bus_s = 1'b0;
        endcase
    end

`ifdef AUDIO_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] ack_cnt_r;
`else
    logic unused_cfg;
    assign unused_cfg = (ACK_TIMEOUT_CYCLES == 0);
`endif

    // Main FSM: issues one bus transaction per bus state and waits for its acknowledge.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_r      <= INIT_CLR;
            fifospace_r  <= 32'h0000_0000;
            left_raw_r   <= 32'h0000_0000;
            address      <= 16'h0000;
            byte_enable  <= 4'h0;
            read         <= 1'b0;
            write        <= 1'b0;
            write_data   <= 32'h0000_0000;
            sample_valid <= 1'b0;
            left_sample  <= 32'h0000_0000;
            right_sample <= 32'h0000_0000;
            frame_count  <= 32'h0000_0000;
            busy         <= 1'b0;
            bus_error    <= 1'b0;
`ifdef AUDIO_ACK_TIMEOUT_EN
            ack_cnt_r    <= {TO_W{1'b0}};
`endif
        end else begin
            sample_valid <= 1'b0;
            busy         <= 1'b1;
            if (is_bus_s && !req_active_s) begin
                address     <= req_addr_s;
                byte_enable <= 4'hF;
                read        <= ~req_write_s;
                write       <= req_write_s;
                write_data  <= req_data_s;
`ifdef AUDIO_ACK_TIMEOUT_EN
                ack_cnt_r   <= {TO_W{1'b0}};
`endif
            end else if (is_bus_s && acknowledge) begin
                address     <= 16'h0000;
                byte_enable <= 4'h0;
                read        <= 1'b0;
                write       <= 1'b0;
                write_data  <= 32'h0000_0000;
                case (state_r)
                    INIT_CLR: state_r <= INIT_REL;
                    INIT_REL: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                    POLL: begin
                        fifospace_r <= read_data;
                        state_r     <= CHECK;
                    end
                    RD_L: begin
                        left_raw_r <= sign_extend(read_data);
                        state_r    <= RD_R;
                    end
                    RD_R: begin
                        left_sample  <= left_raw_r;
                        right_sample <= sign_extend(read_data);
                        sample_valid <= 1'b1;
                        state_r      <= WR_L;
                    end
                    WR_L:     state_r <= WR_R;
                    WR_R: begin
                        frame_count <= frame_count + 32'd1;
                        state_r     <= POLL;
                    end
                    default:  state_r <= INIT_CLR;
                endcase
`ifdef AUDIO_ACK_TIMEOUT_EN
            end else if (is_bus_s) begin
                if (ack_cnt_r == TO_LAST) begin
                    address     <= 16'h0000;
                    byte_enable <= 4'h0;
                    read        <= 1'b0;
                    write       <= 1'b0;
                    write_data  <= 32'h0000_0000;
                    bus_error   <= 1'b1;
                    state_r     <= INIT_CLR;
                end else begin
                    ack_cnt_r <= ack_cnt_r + TO_W'(1);
                end
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        if (enable) begin
                            state_r <= POLL;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    CHECK: begin
                        if (!enable) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end else if (space_ok_s) begin
                            state_r <= RD_L;
                        end else begin
                            state_r <= POLL;
                        end
                    end
                    default: state_r <= state_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_bus_master_streamer.sv
// Directed bench for audio_bus_master_streamer with a logging audio-core bus model.
module tb_audio_bus_master_streamer;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        mute = 1'b0;
    logic [3:0]  volume_shift = 4'd0;
    logic [15:0] address;
    logic [3:0]  byte_enable;
    logic        read;
    logic        write;
    logic [31:0] write_data;
    logic        acknowledge = 1'b0;
    logic [31:0] read_data = 32'h0;
    logic        sample_valid;
    logic [31:0] left_sample;
    logic [31:0] right_sample;
    logic [31:0] frame_count;
    logic        busy;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    audio_bus_master_streamer #(
        .AUDIO_BASE(16'h0000), .SAMPLE_BITS(24), .ACK_TIMEOUT_CYCLES(8)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable), .mute(mute),
        .volume_shift(volume_shift), .address(address), .byte_enable(byte_enable),
        .read(read), .write(write), .write_data(write_data), .acknowledge(acknowledge),
        .read_data(read_data), .sample_valid(sample_valid), .left_sample(left_sample),
        .right_sample(right_sample), .frame_count(frame_count), .busy(busy),
        .bus_error(bus_error)
    );

    always #5 clk_clk = ~clk_clk;

    // Audio core model
    logic [31:0] fifospace = 32'h0;
    logic [31:0] left_data = 32'h0;
    logic [31:0] right_data = 32'h0;
    int          ack_delay = 0;
    bit          no_ack = 1'b0;
    int          stab_err = 0;
    int          sv_cnt = 0;
    logic [15:0] log_addr [64];
    logic        log_wr [64];
    logic [31:0] log_data [64];
    int          log_len [64];
    int          log_n = 0;
    bit          act = 1'b0;
    logic [15:0] cur_addr;
    logic        cur_wr;
    logic [31:0] cur_data;
    int          cur_len;
    int          wcnt;

    always @(negedge clk_clk) begin
        if (read || write) begin
            if (!act) begin
                act = 1'b1; cur_addr = address; cur_wr = write; cur_data = write_data;
                cur_len = 0; wcnt = 0;
            end else if (address !== cur_addr || write !== cur_wr || read !== !cur_wr ||
                         write_data !== cur_data) begin
                stab_err++;
            end
            if (byte_enable !== 4'hF || (read && write)) stab_err++;
            cur_len++;
            if (!acknowledge && !no_ack) begin
                if (wcnt >= ack_delay) begin
                    acknowledge = 1'b1;
                    case (address)
                        16'h0004: read_data = fifospace;
                        16'h0008: read_data = left_data;
                        16'h000C: read_data = right_data;
                        default:  read_data = 32'h0;
                    endcase
                end else begin
                    wcnt++;
                end
            end
        end else begin
            if (act && log_n < 64) begin
                log_addr[log_n] = cur_addr; log_wr[log_n] = cur_wr;
                log_data[log_n] = cur_data; log_len[log_n] = cur_len;
                log_n++;
            end
            act = 1'b0;
            acknowledge = 1'b0;
        end
        if (sample_valid) sv_cnt++;
    end

    task automatic run_one_frame(input logic [31:0] target, output bit ok);
        enable = 1'b1;
        for (int i = 0; i < 300 && frame_count !== target; i++) @(negedge clk_clk);
        ok = (frame_count === target);
        enable = 1'b0;
        for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk_clk);
        ok = ok && (busy === 1'b0);
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        checks++;
        if ({read, write, busy, sample_valid, bus_error} !== 5'b0 || address !== 16'h0 ||
            byte_enable !== 4'h0 || frame_count !== 32'h0 || left_sample !== 32'h0 ||
            right_sample !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b wr=%b busy=%b sv=%b be=%h fc=%h, required all 0",
                     read, write, busy, sample_valid, byte_enable, frame_count);
        end
        log_n = 0;
        reset_reset_n = 1'b1;
        repeat (12) @(negedge clk_clk);
        checks++;
        if (log_n !== 2) begin
            errors++; $display("FAIL init_count: got %0d transactions, required 2", log_n);
        end
        checks++;
        if (log_wr[0] !== 1'b1 || log_addr[0] !== 16'h0 || log_data[0] !== 32'h0000000C) begin
            errors++;
            $display("FAIL init_clear: wr=%b addr=%h data=%h, required 1/0000/0000000c",
                     log_wr[0], log_addr[0], log_data[0]);
        end
        checks++;
        if (log_wr[1] !== 1'b1 || log_addr[1] !== 16'h0 || log_data[1] !== 32'h0) begin
            errors++;
            $display("FAIL init_release: wr=%b addr=%h data=%h, required 1/0000/00000000",
                     log_wr[1], log_addr[1], log_data[1]);
        end
        checks++;
        if (busy !== 1'b0 || log_len[0] !== 1) begin
            errors++; $display("FAIL init_idle: busy=%b len=%0d, required 0/1", busy, log_len[0]);
        end
    endtask

    task automatic test_stream();
        bit ok;
        fifospace = 32'h01010101; left_data = 32'h5A800000; right_data = 32'h00000100;
        volume_shift = 4'd4; mute = 1'b0;
        log_n = 0; sv_cnt = 0;
        run_one_frame(32'd1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stream_timeout: frame_count=%h, required 1", frame_count); end
        checks++;
        if (left_sample !== 32'hFF800000 || right_sample !== 32'h00000100) begin
            errors++;
            $display("FAIL stream_samples: L=%h R=%h, required ff800000/00000100", left_sample, right_sample);
        end
        checks++;
        if (sv_cnt !== 1) begin errors++; $display("FAIL stream_valid: pulses=%0d, required 1", sv_cnt); end
        checks++;
        if (log_addr[0] !== 16'h4 || log_wr[0] !== 1'b0 || log_addr[1] !== 16'h8 || log_wr[1] !== 1'b0 ||
            log_addr[2] !== 16'hC || log_wr[2] !== 1'b0) begin
            errors++;
            $display("FAIL stream_reads: addrs %h %h %h, required 0004 0008 000c reads",
                     log_addr[0], log_addr[1], log_addr[2]);
        end
        checks++;
        if (log_addr[3] !== 16'h8 || log_wr[3] !== 1'b1 || log_data[3] !== 32'hFFF80000 ||
            log_addr[4] !== 16'hC || log_wr[4] !== 1'b1 || log_data[4] !== 32'h00000010) begin
            errors++;
            $display("FAIL stream_writes: %h=%h %h=%h, required 0008=fff80000 000c=00000010",
                     log_addr[3], log_data[3], log_addr[4], log_data[4]);
        end
    endtask

    task automatic test_no_space();
        int bad = 0;
        fifospace = 32'h00010101;
        log_n = 0; sv_cnt = 0;
        enable = 1'b1;
        repeat (40) @(negedge clk_clk);
        enable = 1'b0;
        for (int i = 0; i < 50 && busy !== 1'b0; i++) @(negedge clk_clk);
        for (int i = 0; i < log_n; i++) if (log_addr[i] !== 16'h4 || log_wr[i] !== 1'b0) bad++;
        checks++;
        if (bad != 0 || log_n < 3) begin
            errors++; $display("FAIL nospace_polls: bad=%0d polls=%0d, required 0 bad, >=3 polls", bad, log_n);
        end
        checks++;
        if (frame_count !== 32'd1 || sv_cnt !== 0) begin
            errors++; $display("FAIL nospace_frames: fc=%h sv=%0d, required 1/0", frame_count, sv_cnt);
        end
    endtask

    task automatic test_mute();
        bit ok;
        fifospace = 32'h01010101; left_data = 32'h00123456; right_data = 32'h00FEDCBA;
        mute = 1'b1; volume_shift = 4'd0;
        log_n = 0;
        run_one_frame(32'd2, ok);
        mute = 1'b0;
        checks++;
        if (!ok || log_data[3] !== 32'h0 || log_data[4] !== 32'h0 || log_wr[3] !== 1'b1 || log_wr[4] !== 1'b1) begin
            errors++;
            $display("FAIL mute_writes: ok=%b %h %h, required 00000000 00000000", ok, log_data[3], log_data[4]);
        end
        checks++;
        if (left_sample !== 32'h00123456 || right_sample !== 32'hFFFEDCBA) begin
            errors++;
            $display("FAIL mute_samples: L=%h R=%h, required 00123456/fffedcba", left_sample, right_sample);
        end
    endtask

    task automatic test_shift_boundary();
        bit ok;
        left_data = 32'h00FFFFFF; right_data = 32'h007FFFFF; volume_shift = 4'd15;
        log_n = 0;
        run_one_frame(32'd3, ok);
        checks++;
        if (!ok || log_data[3] !== 32'hFFFFFFFF || log_data[4] !== 32'h000000FF) begin
            errors++;
            $display("FAIL shift15: ok=%b %h %h, required ffffffff 000000ff", ok, log_data[3], log_data[4]);
        end
    endtask

    task automatic test_ack_stretch();
        bit ok;
        left_data = 32'h00000010; right_data = 32'h0000000F; volume_shift = 4'd1;
        ack_delay = 5; log_n = 0; sv_cnt = 0; stab_err = 0;
        run_one_frame(32'd4, ok);
        ack_delay = 0;
        checks++;
        if (!ok || stab_err !== 0) begin
            errors++; $display("FAIL stretch_stable: ok=%b unstable=%0d, required 1/0", ok, stab_err);
        end
        checks++;
        if (log_addr[1] !== 16'h8 || log_len[1] !== 6 || sv_cnt !== 1) begin
            errors++;
            $display("FAIL stretch_rdl: addr=%h len=%0d sv=%0d, required 0008/6/1", log_addr[1], log_len[1], sv_cnt);
        end
        checks++;
        if (log_data[3] !== 32'h00000008 || log_data[4] !== 32'h00000007) begin
            errors++; $display("FAIL stretch_writes: %h %h, required 00000008 00000007", log_data[3], log_data[4]);
        end
    endtask

    task automatic test_reset_mid();
        ack_delay = 10;
        enable = 1'b1;
        for (int i = 0; i < 50 && read !== 1'b1; i++) @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        @(posedge clk_clk); #1;
        checks++;
        if (read !== 1'b0 || write !== 1'b0 || busy !== 1'b0 || frame_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: rd=%b wr=%b busy=%b fc=%h, required 0/0/0/0", read, write, busy, frame_count);
        end
        @(negedge clk_clk); @(negedge clk_clk);
        enable = 1'b0; ack_delay = 0; log_n = 0;
        reset_reset_n = 1'b1;
        repeat (12) @(negedge clk_clk);
        checks++;
        if (log_n !== 2 || log_data[0] !== 32'h0000000C || log_data[1] !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_reinit: n=%0d d0=%h d1=%h busy=%b, required 2/0000000c/00000000/0",
                     log_n, log_data[0], log_data[1], busy);
        end
    endtask

    task automatic test_timeout();
`ifdef AUDIO_ACK_TIMEOUT_EN
        no_ack = 1'b1; log_n = 0;
        enable = 1'b1;
        for (int i = 0; i < 60 && bus_error !== 1'b1; i++) @(negedge clk_clk);
        no_ack = 1'b0; enable = 1'b0;
        checks++;
        if (bus_error !== 1'b1) begin errors++; $display("FAIL timeout_flag: bus_error=%b, required 1", bus_error); end
        repeat (15) @(negedge clk_clk);
        checks++;
        if (log_n < 3 || log_addr[0] !== 16'h4 || log_len[0] !== 8) begin
            errors++; $display("FAIL timeout_len: addr=%h len=%0d, required 0004/8", log_addr[0], log_len[0]);
        end
        checks++;
        if (log_wr[1] !== 1'b1 || log_addr[1] !== 16'h0 || log_data[1] !== 32'h0000000C || bus_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_reinit: wr=%b addr=%h data=%h err=%b, required 1/0000/0000000c/1",
                     log_wr[1], log_addr[1], log_data[1], bus_error);
        end
        reset_reset_n = 1'b0;
        repeat (2) @(negedge clk_clk);
        checks++;
        if (bus_error !== 1'b0) begin errors++; $display("FAIL timeout_clear: bus_error=%b, required 0", bus_error); end
        reset_reset_n = 1'b1;
        repeat (10) @(negedge clk_clk);
`else
        checks++;
        if (bus_error !== 1'b0) begin errors++; $display("FAIL bus_error_tied: bus_error=%b, required 0", bus_error); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_no_space();
        test_mute();
        test_shift_boundary();
        test_ack_stretch();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
